// File: rtl/cs_measure_engine.sv
// Compressed-sensing measurement engine: y[j] = sum_i phi[j][i]*x[i] with an
// LFSR-generated sensing matrix, one MAC per (sample, measurement) pair.
module cs_measure_engine #(
  parameter int          N       = 96,
  parameter int          M       = 16,
  parameter int          W_IN    = 4,
  parameter int          W_ACC   = 12,
  parameter int          BIPOLAR = 1,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               sys_clk,
  input  logic               sys_reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [W_IN-1:0]    in_data,
  output logic               in_ready,
  output logic [7:0]         sample_count,
  output logic               out_valid,
  output logic [W_ACC-1:0]   out_data,
  output logic [5:0]         out_index,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DUMP} state_t;

  localparam int          JW      = (M > 1) ? $clog2(M) : 1;
  localparam logic [5:0]  LAST_J  = 6'(M - 1);
  localparam logic [7:0]  N_FINAL = 8'(N);

  state_t                   state, state_next;
  logic                     armed;
  logic [15:0]              lfsr, lfsr_next;
  logic [W_IN-1:0]          x;
  logic [5:0]               j, k;
  logic [7:0]               count;
  logic                     done;
  logic signed [W_ACC-1:0]  acc [M];
  logic signed [W_ACC-1:0]  x_ext, addend;
  logic                     start_ok, dump_xfer, dump_last;

  // start on the first edge after reset release is dropped via armed
  assign start_ok  = start && armed;
  assign dump_xfer = (state == DUMP) && out_ready;
  assign dump_last = dump_xfer && (k == LAST_J);
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    x_ext = '0;
    x_ext[W_IN-1:0] = x;
    if (BIPOLAR != 0) addend = lfsr[0] ? x_ext : -x_ext;
    else              addend = lfsr[0] ? x_ext : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: if (in_valid) state_next = MAC;
      MAC:  if (j == LAST_J) state_next = (count + 8'd1 == N_FINAL) ? DUMP : LOAD;
      DUMP: if (dump_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      armed <= 1'b0;
      lfsr  <= SEED;
      x     <= '0;
      j     <= '0;
      k     <= '0;
      count <= '0;
      done  <= 1'b0;
      for (int unsigned i = 0; i < M; i++) acc[i] <= '0;
    end else begin
      armed <= 1'b1;
      done  <= dump_last;
      unique case (state)
        IDLE: if (start_ok) begin
          lfsr  <= SEED;
          count <= '0;
          for (int unsigned i = 0; i < M; i++) acc[i] <= '0;
        end
        LOAD: if (in_valid) begin
          x <= in_data;
          j <= '0;
        end
        MAC: begin
          acc[j[JW-1:0]] <= acc[j[JW-1:0]] + addend;
          lfsr <= lfsr_next;
          j    <= j + 6'd1;
          if (j == LAST_J) begin
            count <= count + 8'd1;
            k     <= '0;
          end
        end
        DUMP: if (dump_xfer) k <= k + 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready     = (state == LOAD);
    busy         = (state != IDLE);
    out_valid    = (state == DUMP);
    out_data     = out_valid ? acc[k[JW-1:0]] : '0;
    out_index    = out_valid ? k : '0;
    sample_count = count;
    frame_done   = done;
  end

endmodule

// File: tb/tb_cs_measure_engine.sv
// Directed bench for cs_measure_engine: one bipolar and one unipolar instance
// driven in lockstep, compared against an LFSR reference model.
module tb_cs_measure_engine;
  localparam int N = 96;
  localparam int M = 16;

  logic        sys_clk = 1'b0, sys_reset = 1'b0, start = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_data = '0;
  logic        ready_b, ready_u, ov_b, ov_u, busy_b, busy_u, fd_b, fd_u;
  logic [7:0]  count_b, count_u;
  logic [11:0] od_b, od_u;
  logic [5:0]  oi_b, oi_u;

  cs_measure_engine #(.N(N), .M(M), .W_IN(4), .W_ACC(12), .BIPOLAR(1), .SEED(16'hACE1)) dut_b (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ready_b), .sample_count(count_b), .out_valid(ov_b),
    .out_data(od_b), .out_index(oi_b), .out_ready(out_ready), .busy(busy_b), .frame_done(fd_b));

  cs_measure_engine #(.N(N), .M(M), .W_IN(4), .W_ACC(12), .BIPOLAR(0), .SEED(16'hACE1)) dut_u (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ready_u), .sample_count(count_u), .out_valid(ov_u),
    .out_data(od_u), .out_index(oi_u), .out_ready(out_ready), .busy(busy_u), .frame_done(fd_u));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [3:0]         xs [N];
  logic signed [11:0] exp_b [M], exp_u [M], got_b [M], got_u [M];
  bit  to_feed, to_col, stall_ok, order_ok, fd_ok;
  int  first_cyc, start_cyc;

  function automatic void compute_expected();
    logic [15:0] lf = 16'hACE1;
    int sb [M];
    int su [M];
    for (int j = 0; j < M; j++) begin sb[j] = 0; su[j] = 0; end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) begin
        if (lf[0]) begin sb[j] += int'(xs[i]); su[j] += int'(xs[i]); end
        else       sb[j] -= int'(xs[i]);
        lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
      end
    for (int j = 0; j < M; j++) begin exp_b[j] = 12'(sb[j]); exp_u[j] = 12'(su[j]); end
  endfunction

  task automatic pulse_start(input bit now);
    if (!now) @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic feed(input int n, input bit toggle, input int glitch_at, output bit timeout);
    int i = 0;
    int budget = 0;
    bit v;
    timeout = 1'b0;
    while (i < n) begin
      @(negedge sys_clk);
      budget++;
      if (budget > 6000) begin timeout = 1'b1; break; end
      v = toggle ? ($urandom_range(0, 1) == 1) : 1'b1;
      start    = (glitch_at >= 0) && (i == glitch_at) && ready_b;
      in_valid = v;
      in_data  = (v && ready_b) ? xs[i] : 4'($urandom);
      if (v && ready_b) i++;
    end
    @(negedge sys_clk);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_at, input bit glitch, output bit timeout);
    int n = 0;
    int budget = 0;
    int stall_cnt = 0;
    logic [11:0] hold_b, hold_u;
    logic [5:0]  hold_i;
    timeout = 1'b0; stall_ok = 1'b1; order_ok = 1'b1; fd_ok = 1'b0; first_cyc = -1;
    hold_b = '0; hold_u = '0; hold_i = '0;
    for (int m = 0; m < M; m++) begin got_b[m] = 'x; got_u[m] = 'x; end
    while (n < M) begin
      if (n > 0 || first_cyc >= 0 || budget > 0) @(negedge sys_clk);
      budget++;
      if (budget > 3000) begin timeout = 1'b1; break; end
      if (ov_b && first_cyc < 0) first_cyc = cyc;
      start = glitch && ov_b && (n == 3);
      if (stall_at >= 0 && n == stall_at && ov_b && stall_cnt < 5) begin
        if (stall_cnt == 0) begin hold_b = od_b; hold_u = od_u; hold_i = oi_b; end
        else if (od_b !== hold_b || od_u !== hold_u || oi_b !== hold_i) stall_ok = 1'b0;
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        if (stall_cnt == 5 && n == stall_at &&
            (od_b !== hold_b || od_u !== hold_u || oi_b !== hold_i)) stall_ok = 1'b0;
        out_ready = 1'b1;
      end
      if (out_ready && ov_b) begin
        if (oi_b !== 6'(n)) order_ok = 1'b0;
        got_b[oi_b[3:0]] = od_b;
        n++;
      end
      if (out_ready && ov_u) got_u[oi_u[3:0]] = od_u;
    end
    start = 1'b0;
    if (stall_at >= 0 && stall_cnt != 5) stall_ok = 1'b0;
    if (!timeout) begin
      @(negedge sys_clk);
      fd_ok = (fd_b === 1'b1) && (fd_u === 1'b1);
    end
  endtask

  task automatic run_frame(input bit now, input bit toggle, input int glitch_at,
                           input bit glitch_dump, input int stall_at);
    out_ready = 1'b1;
    pulse_start(now);
    feed(N, toggle, glitch_at, to_feed);
    collect(stall_at, glitch_dump, to_col);
  endtask

  task automatic check_frame(input string tag);
    checks++;
    if (to_feed || to_col) begin
      errors++; $display("FAIL %s timeout: feed=%0d collect=%0d, required 0 0", tag, to_feed, to_col);
    end
    checks++;
    if (!order_ok) begin errors++; $display("FAIL %s out_index order: got out of sequence, required 0..%0d", tag, M-1); end
    checks++;
    if (!fd_ok) begin errors++; $display("FAIL %s frame_done: got %b/%b, required 1", tag, fd_b, fd_u); end
    checks++;
    if (count_b !== 8'(N)) begin errors++; $display("FAIL %s sample_count: got %0d, required %0d", tag, count_b, N); end
    for (int j = 0; j < M; j++) begin
      checks++;
      if (got_b[j] !== exp_b[j]) begin
        errors++; $display("FAIL %s bipolar y[%0d]: got %0d, required %0d", tag, j, got_b[j], exp_b[j]);
      end
      checks++;
      if (got_u[j] !== exp_u[j]) begin
        errors++; $display("FAIL %s unipolar y[%0d]: got %0d, required %0d", tag, j, got_u[j], exp_u[j]);
      end
    end
  endtask

  task automatic test_reset();
    sys_reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (ov_b !== 1'b0 || busy_b !== 1'b0 || ready_b !== 1'b0 || fd_b !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b done=%b, required 0 0 0 0", ov_b, busy_b, ready_b, fd_b);
    end
    checks++;
    if (od_b !== 12'd0 || oi_b !== 6'd0 || count_b !== 8'd0) begin
      errors++; $display("FAIL reset_data: got data=%0d index=%0d count=%0d, required 0 0 0", od_b, oi_b, count_b);
    end
    sys_reset = 1'b1;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL start_at_release: got busy=%b, required 0", busy_b); end
  endtask

  task automatic test_zero_frame();
    for (int i = 0; i < N; i++) xs[i] = 4'd0;
    compute_expected();
    run_frame(1'b0, 1'b0, -1, 1'b0, -1);
    checks++;
    if (first_cyc - start_cyc + 1 != N * (M + 1) + 1) begin
      errors++; $display("FAIL latency: got %0d cycles, required %0d", first_cyc - start_cyc + 1, N * (M + 1) + 1);
    end
    check_frame("zero");
    @(negedge sys_clk);
    checks++;
    if (fd_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=%b busy=%b, required 0 0", fd_b, busy_b);
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < N; i++) xs[i] = 4'd0;
    xs[8] = 4'd1;
    compute_expected();
    run_frame(1'b0, 1'b0, -1, 1'b0, -1);
    check_frame("impulse");
  endtask

  task automatic test_constant();
    for (int i = 0; i < N; i++) xs[i] = 4'd15;
    compute_expected();
    run_frame(1'b0, 1'b0, -1, 1'b0, -1);
    check_frame("constant");
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) xs[i] = 4'd15;
    compute_expected();
    run_frame(1'b0, 1'b1, -1, 1'b0, 5);
    check_frame("stall");
    checks++;
    if (!stall_ok) begin errors++; $display("FAIL stall_hold: got output change while stalled, required stable"); end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < N; i++) xs[i] = 4'((i * 7 + 3) % 16);
    compute_expected();
    out_ready = 1'b1;
    pulse_start(1'b0);
    feed(41, 1'b0, -1, to_feed);
    repeat (4) @(negedge sys_clk);
    checks++;
    if (busy_b !== 1'b1 || count_b !== 8'd40) begin
      errors++; $display("FAIL pre_reset: got busy=%b count=%0d, required 1 40", busy_b, count_b);
    end
    sys_reset = 1'b0;
    #1;
    checks++;
    if (busy_b !== 1'b0 || ready_b !== 1'b0 || ov_b !== 1'b0 || count_b !== 8'd0 || od_b !== 12'd0) begin
      errors++; $display("FAIL mid_reset: got busy=%b ready=%b valid=%b count=%0d data=%0d, required 0 0 0 0 0",
                         busy_b, ready_b, ov_b, count_b, od_b);
    end
    @(negedge sys_clk);
    sys_reset = 1'b1;
    run_frame(1'b0, 1'b0, -1, 1'b0, -1);
    check_frame("after_reset");
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < N; i++) xs[i] = 4'((i * 5 + 11) % 16);
    compute_expected();
    run_frame(1'b0, 1'b0, 10, 1'b1, -1);
    check_frame("start_ignored");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) xs[i] = 4'((i * 3 + 1) % 16);
    compute_expected();
    run_frame(1'b0, 1'b0, -1, 1'b0, -1);
    check_frame("b2b_first");
    run_frame(1'b1, 1'b0, -1, 1'b0, -1);
    check_frame("b2b_second");
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_impulse();
    test_constant();
    test_stall();
    test_reset_mid_frame();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
